// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : RV64 instruction fetch unit. Holds the PC, issues one
//               instruction-memory read per instruction and hands each word
//               to decode. The next PC is selected at commit.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic [1:0]      npc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            halt,
    output logic            halted,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [63:0]     instret
);

    localparam logic [2:0]  c_ST_BOOT  = 3'd0;
    localparam logic [2:0]  c_ST_REQ   = 3'd1;
    localparam logic [2:0]  c_ST_WAIT  = 3'd2;
    localparam logic [2:0]  c_ST_HOLD  = 3'd3;
    localparam logic [2:0]  c_ST_HALT  = 3'd4;
    localparam logic [2:0]  c_ST_FAULT = 3'd5;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_fault_pc;
    logic [63:0]     r_instret;

    logic            w_rsp_ok;
    logic            w_rsp_fault;
    logic            w_commit;
    logic [XLEN-1:0] w_jalr_aligned;
    logic [XLEN-1:0] w_npc;
    logic            w_npc_misaligned;

    assign w_rsp_ok    = (r_state == c_ST_WAIT) && imem_rsp_valid && !imem_rsp_err;
    assign w_rsp_fault = (r_state == c_ST_WAIT) && imem_rsp_valid &&  imem_rsp_err;
    assign w_commit    = (r_state == c_ST_HOLD) && instr_ready;

    // jalr target loses bit 0; select bit 1 takes priority over bit 0
    assign w_jalr_aligned   = jalr_target & ~XLEN'(1);
    assign w_npc            = npc_sel[1] ? w_jalr_aligned :
                              npc_sel[0] ? branch_target  :
                                           r_pc + XLEN'(4);
    assign w_npc_misaligned = (w_npc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_BOOT: w_state_nxt = c_ST_REQ;
            c_ST_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = imem_rsp_err ? c_ST_FAULT : c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (instr_ready) begin
                    if (halt) begin
                        w_state_nxt = c_ST_HALT;
                    end else if (w_npc_misaligned) begin
                        w_state_nxt = c_ST_FAULT;
                    end else begin
                        w_state_nxt = c_ST_REQ;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= c_NOP;
            r_instr_pc <= '0;
            r_fault_pc <= '0;
            r_instret  <= '0;
        end else begin
            if (w_rsp_ok) begin
                r_instr    <= imem_rsp_data;
                r_instr_pc <= r_pc;
            end
            if (w_rsp_fault) begin
                r_fault_pc <= r_pc;
            end
            if (w_commit) begin
                r_instret <= r_instret + 64'd1;
                // a halting instruction keeps the PC; its npc is meaningless
                if (!halt) begin
                    if (w_npc_misaligned) begin
                        r_fault_pc <= w_npc;
                    end else begin
                        r_pc <= w_npc;
                    end
                end
            end
        end
    end

    assign imem_req_valid = (r_state == c_ST_REQ);
    assign imem_req_addr  = r_pc;
    assign instr_valid    = (r_state == c_ST_HOLD);
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign halted         = (r_state == c_ST_HALT);
    assign fetch_fault    = (r_state == c_ST_FAULT);
    assign fault_pc       = r_fault_pc;
    assign instret        = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Directed bench for ifu_fetch with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_err   = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [1:0]  npc_sel = 2'd0;
    logic [63:0] branch_target = 64'h0;
    logic [63:0] jalr_target   = 64'h0;
    logic        halt = 1'b0;
    logic        halted;
    logic        fetch_fault;
    logic [63:0] fault_pc;
    logic [63:0] instret;

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .npc_sel(npc_sel), .branch_target(branch_target), .jalr_target(jalr_target),
        .halt(halt), .halted(halted), .fetch_fault(fetch_fault),
        .fault_pc(fault_pc), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // memory: one pending read, fixed latency, error on a chosen address
    int          mem_lat   = 1;
    int          pend_cnt  = 0;
    logic [63:0] pend_addr = 64'h0;
    logic [63:0] err_addr  = 64'h1;

    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            pend_addr = imem_req_addr;
            pend_cnt  = mem_lat;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                imem_rsp_err   = (pend_addr == err_addr);
            end
        end
    end

    // architectural model: pc, one outstanding fetch, held instruction, stop flags
    logic [63:0] m_pc       = RESET_PC;
    logic [63:0] m_instret  = 64'h0;
    logic [63:0] m_fault_pc = 64'h0;
    logic [63:0] m_npc;
    bit          m_out = 0, m_hold = 0, m_halted = 0, m_fault = 0;
    logic [63:0] hs_addr[$];
    int          hs_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            m_pc = RESET_PC; m_instret = 64'h0; m_fault_pc = 64'h0;
            m_out = 0; m_hold = 0; m_halted = 0; m_fault = 0;
        end else begin
            chk("instr_valid", {63'h0, instr_valid}, {63'h0, m_hold});
            if (instr_valid) begin
                chk("instr", {32'h0, instr}, {32'h0, mem_word(m_pc)});
                chk("instr_pc", instr_pc, m_pc);
            end
            if (imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
            if (m_out || m_hold || m_halted || m_fault)
                chk("req_idle", {63'h0, imem_req_valid}, 64'h0);
            chk("instret", instret, m_instret);
            chk("halted", {63'h0, halted}, {63'h0, m_halted});
            chk("fetch_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
            if (m_fault) chk("fault_pc", fault_pc, m_fault_pc);

            if (m_out && imem_rsp_valid) begin
                m_out = 0;
                if (imem_rsp_err) begin
                    m_fault = 1; m_fault_pc = m_pc;
                end else begin
                    m_hold = 1;
                end
            end else if (imem_req_valid && imem_req_ready && !m_hold && !m_halted && !m_fault) begin
                m_out = 1;
                hs_addr.push_back(imem_req_addr);
                hs_cyc.push_back(cyc);
            end else if (m_hold && instr_ready) begin
                m_hold    = 0;
                m_instret = m_instret + 64'd1;
                if (npc_sel[1])      m_npc = {jalr_target[63:1], 1'b0};
                else if (npc_sel[0]) m_npc = branch_target;
                else                 m_npc = m_pc + 64'd4;
                if (halt)                    m_halted = 1;
                else if (m_npc[1:0] != 2'b0) begin m_fault = 1; m_fault_pc = m_npc; end
                else                         m_pc = m_npc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!imem_req_valid && k < 50) begin tick(); k++; end
        if (!imem_req_valid) tmo(name);
    endtask

    task automatic wait_noreq(input string name);
        int k = 0;
        while (imem_req_valid && k < 50) begin tick(); k++; end
        if (imem_req_valid) tmo(name);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!instr_valid && k < 50) begin tick(); k++; end
        if (!instr_valid) tmo(name);
    endtask

    task automatic wait_fault(input string name);
        int k = 0;
        while (!fetch_fault && k < 50) begin tick(); k++; end
        if (!fetch_fault) tmo(name);
    endtask

    task automatic wait_instret(input logic [63:0] n, input string name);
        int k = 0;
        while (instret != n && k < 60) begin tick(); k++; end
        if (instret != n) tmo(name);
    endtask

    logic [31:0] inst0;
    logic [63:0] ipc0;
    logic [63:0] ir0;
    int          nv, k;
    bit          seen;

    initial begin
        // reset state
        tick();
        chk("rst_instr", {32'h0, instr}, 64'h13);
        chk("rst_instr_pc", instr_pc, 64'h0);
        chk("rst_instret", instret, 64'h0);
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_fault_pc", fault_pc, 64'h0);
        tick();
        rst = 1'b0;

        // back-to-back sequential fetch
        wait_instret(64'd3, "three_commits");
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        mem_lat        = 5;
        if (hs_addr.size() >= 3) begin
            chk("seq_addr0", hs_addr[0], 64'h8000_0000);
            chk("seq_addr1", hs_addr[1], 64'h8000_0004);
            chk("seq_addr2", hs_addr[2], 64'h8000_0008);
            chk("seq_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            chk("seq_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end else tmo("seq_handshakes");

        // request back-pressure, slow memory
        repeat (4) begin
            chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h1);
            chk("stall_req_addr", imem_req_addr, 64'h8000_000C);
            tick();
        end
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        nv = 0; k = 0; seen = 0;
        while (k < 20 && !(seen && imem_req_valid)) begin
            tick(); k++;
            if (instr_valid) begin nv++; seen = 1; end
        end
        if (!(seen && imem_req_valid)) tmo("slow_mem_next_req");
        mem_lat = 1;
        chk("slow_mem_valid_count", 64'(nv), 64'd1);
        chk("slow_mem_next_addr", imem_req_addr, 64'h8000_0010);

        // branch then jalr redirection
        npc_sel = 2'd1; branch_target = 64'h8000_0040;
        wait_noreq("br_noreq"); wait_req("br_req");
        chk("branch_addr", imem_req_addr, 64'h8000_0040);
        npc_sel = 2'd3; jalr_target = 64'h8000_0101;
        wait_noreq("jalr_noreq"); wait_req("jalr_req");
        chk("jalr_addr", imem_req_addr, 64'h8000_0100);

        // decode stall then halt
        instr_ready = 1'b0; npc_sel = 2'd0;
        wait_valid("hold_valid");
        inst0 = instr; ipc0 = instr_pc; ir0 = instret;
        chk("hold_pc", ipc0, 64'h8000_0100);
        chk("hold_instret", ir0, 64'd6);
        repeat (3) begin
            tick();
            chk("hold_instr_stable", {32'h0, instr}, {32'h0, inst0});
            chk("hold_pc_stable", instr_pc, ipc0);
            chk("hold_instret_stable", instret, ir0);
        end
        halt = 1'b1; instr_ready = 1'b1;
        tick();
        halt = 1'b0; instr_ready = 1'b0;
        chk("halted", {63'h0, halted}, 64'h1);
        chk("halt_instret", instret, 64'd7);
        repeat (5) begin
            tick();
            chk("halt_no_req", {63'h0, imem_req_valid}, 64'h0);
        end

        // response error
        rst = 1'b1; tick();
        err_addr = 64'h8000_0008; instr_ready = 1'b1; npc_sel = 2'd0;
        rst = 1'b0;
        wait_fault("rsp_err_fault");
        chk("rsp_err_fault_pc", fault_pc, 64'h8000_0008);
        chk("rsp_err_instret", instret, 64'd2);
        repeat (3) begin
            tick();
            chk("fault_no_valid", {63'h0, instr_valid}, 64'h0);
        end

        // misaligned branch target
        rst = 1'b1; tick();
        err_addr = 64'h1; npc_sel = 2'd1; branch_target = 64'h8000_0042;
        rst = 1'b0;
        wait_fault("misalign_fault");
        chk("misalign_fault_pc", fault_pc, 64'h8000_0042);
        chk("misalign_instret", instret, 64'd1);

        // reset while waiting for a response, stale response afterwards
        rst = 1'b1; tick();
        npc_sel = 2'd0; mem_lat = 1;
        rst = 1'b0;
        wait_instret(64'd1, "pre_reset_commit");
        mem_lat = 5;
        tick();
        tick();
        chk("pre_reset_instret", instret, 64'd1);
        chk("pre_reset_instr_pc", instr_pc, 64'h8000_0000);
        imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_instret", instret, 64'h0);
        chk("async_instr_pc", instr_pc, 64'h0);
        chk("async_instr", {32'h0, instr}, 64'h13);
        chk("async_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("stale_ignored", {63'h0, instr_valid}, 64'h0);
        chk("restart_req", {63'h0, imem_req_valid}, 64'h1);
        chk("restart_addr", imem_req_addr, RESET_PC);
        mem_lat = 1; imem_req_ready = 1'b1;
        wait_instret(64'd1, "restart_commit");
        chk("restart_instr_pc", instr_pc, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
